// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants and mul/div unit types
package mips_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_t;

    function automatic logic mdu_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between core and mul/div unit
interface mul_div_unit_if
    import mips_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             START;
    logic [1:0]       OP;
    logic [WIDTH-1:0] SRCA;
    logic [WIDTH-1:0] SRCB;
    logic             HI_WE;
    logic             LO_WE;
    logic [WIDTH-1:0] HILO_WD;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, OP, SRCA, SRCB, HI_WE, LO_WE, HILO_WD,
        input  HI, LO, BUSY, DONE
    );

    modport slave (
        input  START, OP, SRCA, SRCB, HI_WE, LO_WE, HILO_WD,
        output HI, LO, BUSY, DONE
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - conditional two's-complement negate
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);
    // Negation wraps modulo 2^WIDTH, so the most negative value maps to itself.
    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;
endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic          CLK,
    input  logic          RST_N,
    mul_div_unit_if.slave bus
);
    // Counter runs one past the last arithmetic step so the unit stays busy WIDTH+2 cycles.
    localparam int CW = $clog2(WIDTH + 2);

    mdu_state_t         r_state;
    mdu_op_t            r_op;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_div0;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH:0]   r_acc;
    logic [CW-1:0]      r_cnt;

    mdu_op_t            w_op;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;

    logic [WIDTH:0]     w_mul_upper;
    logic [2*WIDTH:0]   w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic               w_qbit;
    logic [WIDTH:0]     w_rem;
    logic [2*WIDTH:0]   w_div_next;

    logic               w_sign_diff;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    assign w_op     = mdu_op_t'(bus.OP);
    assign w_sign_a = mdu_is_signed(w_op) & bus.SRCA[WIDTH-1];
    assign w_sign_b = mdu_is_signed(w_op) & bus.SRCB[WIDTH-1];

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .i_val (bus.SRCA),
        .i_neg (w_sign_a),
        .o_val (w_abs_a)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .i_val (bus.SRCB),
        .i_neg (w_sign_b),
        .o_val (w_abs_b)
    );

    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_upper = r_acc[2*WIDTH:WIDTH] + {1'b0, (r_a[0] ? r_b : {WIDTH{1'b0}})};
    assign w_mul_next  = {1'b0, w_mul_upper, r_acc[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the partial remainder,
    // subtract the divisor when it fits and record the quotient bit at the bottom.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_b};
    assign w_qbit     = ~w_diff[WIDTH+1];
    assign w_rem      = w_qbit ? w_diff[WIDTH:0] : w_rem_sh;
    assign w_div_next = {w_rem, r_acc[WIDTH-2:0], w_qbit};

    assign w_sign_diff = r_neg_a ^ r_neg_b;

    mdu_sign_fix #(.WIDTH(2*WIDTH)) u_fix_prod (
        .i_val (r_acc[2*WIDTH-1:0]),
        .i_neg (w_sign_diff),
        .o_val (w_prod_fix)
    );

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quot (
        .i_val (r_acc[WIDTH-1:0]),
        .i_neg (w_sign_diff),
        .o_val (w_quot_fix)
    );

    // Truncating division: remainder follows the dividend's sign.
    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
        .i_val (r_acc[2*WIDTH-1:WIDTH]),
        .i_neg (r_neg_a),
        .o_val (w_rem_fix)
    );

    // A zero divisor leaves the dividend as remainder; the quotient is forced
    // to all ones regardless of the dividend's sign.
    assign w_hi_res = r_op[1] ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_res = r_op[1] ? (r_div0 ? {WIDTH{1'b1}} : w_quot_fix)
                              : w_prod_fix[WIDTH-1:0];

    // Control FSM, iteration datapath and HI/LO architectural state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_op    <= MDU_MULT;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_div0  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.START) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_op    <= w_op;
                        r_neg_a <= w_sign_a;
                        r_neg_b <= w_sign_b;
                        r_div0  <= (bus.SRCB == '0);
                        r_a     <= w_abs_a;
                        r_b     <= w_abs_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        if (bus.HI_WE) r_hi <= bus.HILO_WD;
                        if (bus.LO_WE) r_lo <= bus.HILO_WD;
                    end
                end
                S_RUN: begin
                    if (r_cnt < CW'(WIDTH)) begin
                        if (r_op[1]) begin
                            r_acc <= w_div_next;
                            r_a   <= r_a << 1;
                        end else begin
                            r_acc <= w_mul_next;
                            r_a   <= r_a >> 1;
                        end
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH)) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_hi_res;
                    r_lo    <= w_lo_res;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;
    assign bus.BUSY = r_busy;
    assign bus.DONE = r_done;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed-vector bench for mul_div_unit
module tb_mul_div_unit;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    int   lat;
    int   bcnt;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mt_write(input logic hi_we, input logic lo_we, input logic [31:0] wd);
        @(negedge clk);
        bus.HI_WE   = hi_we;
        bus.LO_WE   = lo_we;
        bus.HILO_WD = wd;
        @(posedge clk);
        #1;
        bus.HI_WE = 1'b0;
        bus.LO_WE = 1'b0;
    endtask

    // kind: 0 plain, 1 re-pulse START at icyc, 2 MTLO at icyc, 3 MTLO on the START edge
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int kind, input int icyc, input logic [31:0] old_lo,
                          output int o_lat, output int o_bcnt);
        @(negedge clk);
        bus.START = 1'b1;
        bus.OP    = op;
        bus.SRCA  = a;
        bus.SRCB  = b;
        if (kind == 3) begin
            bus.LO_WE   = 1'b1;
            bus.HILO_WD = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        bus.LO_WE = 1'b0;
        bus.OP    = 2'b10;
        bus.SRCA  = 32'h1234_5678;
        bus.SRCB  = 32'h0;
        if (kind == 3) chk("mtlo_with_start", {32'h0, bus.LO}, {32'h0, old_lo});
        o_lat  = 0;
        o_bcnt = 0;
        while (!bus.DONE && o_lat < 100) begin
            if (bus.BUSY) o_bcnt++;
            @(negedge clk);
            if (kind == 1 && o_lat == icyc) begin
                bus.START = 1'b1;
                bus.OP    = 2'b10;
                bus.SRCA  = 32'd100;
                bus.SRCB  = 32'd7;
            end
            if (kind == 2 && o_lat == icyc) begin
                bus.LO_WE   = 1'b1;
                bus.HILO_WD = 32'hDEAD_BEEF;
            end
            @(posedge clk);
            #1;
            bus.START = 1'b0;
            bus.LO_WE = 1'b0;
            o_lat++;
            if (kind == 2 && o_lat == icyc + 1)
                chk("mtlo_busy", {32'h0, bus.LO}, {32'h0, old_lo});
        end
    endtask

    task automatic expect_op(input string tag, input logic [31:0] ehi, input logic [31:0] elo,
                             input int r_lat, input int r_bcnt);
        chk({tag, "_lat"},  64'(r_lat), 64'd34);
        chk({tag, "_busy"}, 64'(r_bcnt), 64'd34);
        chk({tag, "_hi"},   {32'h0, bus.HI}, {32'h0, ehi});
        chk({tag, "_lo"},   {32'h0, bus.LO}, {32'h0, elo});
        chk({tag, "_idle"}, {63'h0, bus.BUSY}, 64'd0);
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        bus.START   = 1'b0;
        bus.OP      = 2'b00;
        bus.SRCA    = '0;
        bus.SRCB    = '0;
        bus.HI_WE   = 1'b0;
        bus.LO_WE   = 1'b0;
        bus.HILO_WD = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'h0, bus.BUSY}, 64'd0);
        chk("rst_done", {63'h0, bus.DONE}, 64'd0);
        chk("rst_hi",   {32'h0, bus.HI}, 64'd0);
        chk("rst_lo",   {32'h0, bus.LO}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0, -1, 32'h0, lat, bcnt);
        expect_op("mult_7x-3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, lat, bcnt);
        chk("mult_done_pulse", {63'h0, bus.DONE}, 64'd1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", {63'h0, bus.DONE}, 64'd0);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 32'h0, lat, bcnt);
        expect_op("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, lat, bcnt);

        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, -1, 32'h0, lat, bcnt);
        expect_op("div_-7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, lat, bcnt);

        run_op(2'b11, 32'd100, 32'd7, 0, -1, 32'h0, lat, bcnt);
        expect_op("divu_100/7", 32'd2, 32'd14, lat, bcnt);

        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, -1, 32'h0, lat, bcnt);
        expect_op("div_7/-2", 32'd1, 32'hFFFF_FFFD, lat, bcnt);

        run_op(2'b11, 32'd100, 32'd0, 0, -1, 32'h0, lat, bcnt);
        expect_op("divu_by0", 32'h0000_0064, 32'hFFFF_FFFF, lat, bcnt);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1, 32'h0, lat, bcnt);
        expect_op("div_ovf", 32'h0, 32'h8000_0000, lat, bcnt);

        mt_write(1'b1, 1'b0, 32'hAAAA_5555);
        chk("mthi_hi", {32'h0, bus.HI}, {32'h0, 32'hAAAA_5555});
        chk("mthi_lo_kept", {32'h0, bus.LO}, {32'h0, 32'h8000_0000});
        mt_write(1'b0, 1'b1, 32'h1357_9BDF);
        chk("mtlo_lo", {32'h0, bus.LO}, {32'h0, 32'h1357_9BDF});

        run_op(2'b01, 32'd2, 32'd3, 3, -1, 32'h1357_9BDF, lat, bcnt);
        expect_op("multu_2x3", 32'h0, 32'd6, lat, bcnt);

        run_op(2'b00, 32'd5, 32'd6, 1, 10, 32'h0, lat, bcnt);
        expect_op("mult_5x6_restart", 32'h0, 32'd30, lat, bcnt);

        run_op(2'b01, 32'd9, 32'd9, 2, 5, 32'd30, lat, bcnt);
        expect_op("multu_9x9", 32'h0, 32'd81, lat, bcnt);

        mt_write(1'b1, 1'b0, 32'h5A5A_0F0F);
        @(negedge clk);
        bus.START = 1'b1;
        bus.OP    = 2'b00;
        bus.SRCA  = 32'd5;
        bus.SRCB  = 32'd6;
        @(posedge clk);
        #1;
        bus.START = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'h0, bus.BUSY}, 64'd0);
        chk("abort_done", {63'h0, bus.DONE}, 64'd0);
        chk("abort_hi",   {32'h0, bus.HI}, 64'd0);
        chk("abort_lo",   {32'h0, bus.LO}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b01, 32'd3, 32'd4, 0, -1, 32'h0, lat, bcnt);
        expect_op("multu_3x4_post_rst", 32'h0, 32'd12, lat, bcnt);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
